lfsr_rr_server: RTL and testbench

Shares one 4-bit pseudo-random source among four requesters. Owns a maximal-length 4-bit Fibonacci LFSR and a round-robin arbiter. Each granted request receives the current LFSR value, and the LFSR then advances one step. Software or a parent block can reseed the LFSR at runtime. The block sits between the LFSR datapath and its consumers, which are test-pattern and backoff logic.

---
 rtl/lfsr_rr_server.sv | 68 ++++++
 tb/tb_lfsr_rr_server.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rr_server.sv
// lfsr_rr_server: round-robin arbiter serving values from a reseedable 4-bit maximal-length LFSR
module lfsr_rr_server #(
   parameter logic [3:0] SEED_RST = 4'b1010,
   parameter int         CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       req,
   input  logic             seed_load,
   input  logic [3:0]       seed_i,
   output logic [3:0]       gnt,
   output logic [3:0]       rnd_o,
   output logic             busy,
   output logic [3:0]       lfsr_o,
   output logic [CNT_W-1:0] serve_cnt
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state_d, state_q;
   logic [3:0] q_d, q_q, seed_nz;
   logic [1:0] last_d, last_q, pick, idx;
   logic found;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = last_q + 2'(i);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end
   // a zero seed would lock the LFSR, so it is replaced by 0001
   assign seed_nz = (seed_i == 4'b0000) ? 4'b0001 : seed_i;
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      q_d     = seed_load ? seed_nz : (state_q == GRANT) ? {q_q[2:0], q_q[3] ^ q_q[0]} : q_q;
      if (state_q == GRANT) begin
         state_d = IDLE;
         cnt_d   = cnt_q + CNT_W'(1);
      end else if (!seed_load && found) begin
         state_d = GRANT;
         last_d  = pick;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= SEED_RST;
         last_q  <= 2'd3;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end
   assign busy      = (state_q == GRANT);
   assign gnt       = busy ? 4'b0001 << last_q : 4'b0000;
   assign rnd_o     = busy ? q_q : 4'b0000;
   assign lfsr_o    = q_q;
   assign serve_cnt = cnt_q;
endmodule

// File: tb/tb_lfsr_rr_server.sv
// tb_lfsr_rr_server: directed scenario tests for lfsr_rr_server
module tb_lfsr_rr_server;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = '0;
   logic       seed_load = 1'b0;
   logic [3:0] seed_i = '0;
   logic [3:0] gnt, rnd_o, lfsr_o;
   logic       busy;
   logic [7:0] serve_cnt;
   int nvec = 0;
   int nerr = 0;

   lfsr_rr_server dut (
      .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_i(seed_i),
      .gnt(gnt), .rnd_o(rnd_o), .busy(busy), .lfsr_o(lfsr_o), .serve_cnt(serve_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; seed_load = 1'b0; seed_i = '0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL reset_gnt got %b want 0000", gnt); end
      nvec++; if (rnd_o !== 4'b0000) begin nerr++; $display("FAIL reset_rnd got %b want 0000", rnd_o); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
      nvec++; if (lfsr_o !== 4'b1010) begin nerr++; $display("FAIL reset_lfsr got %b want 1010", lfsr_o); end
      nvec++; if (serve_cnt !== 8'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", serve_cnt); end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001;
      step();
      nvec++; if (gnt !== 4'b0001) begin nerr++; $display("FAIL single_gnt got %b want 0001", gnt); end
      nvec++; if (rnd_o !== 4'b1010) begin nerr++; $display("FAIL single_rnd got %b want 1010", rnd_o); end
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy got %b want 1", busy); end
      req = 4'b0000;
      step();
      nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL single_gnt_drop got %b want 0000", gnt); end
      nvec++; if (lfsr_o !== 4'b0101) begin nerr++; $display("FAIL single_lfsr got %b want 0101", lfsr_o); end
      nvec++; if (serve_cnt !== 8'd1) begin nerr++; $display("FAIL single_cnt got %0d want 1", serve_cnt); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_rnd [4] = '{4'b1010, 4'b0101, 4'b1011, 4'b0110};
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         step();
         nvec++; if (gnt !== (4'b0001 << k)) begin nerr++; $display("FAIL rr_gnt%0d got %b want %b", k, gnt, 4'b0001 << k); end
         nvec++; if (rnd_o !== exp_rnd[k]) begin nerr++; $display("FAIL rr_rnd%0d got %b want %b", k, rnd_o, exp_rnd[k]); end
         step();
         nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL rr_idle%0d got %b want 0000", k, gnt); end
      end
      nvec++; if (serve_cnt !== 8'd4) begin nerr++; $display("FAIL rr_cnt got %0d want 4", serve_cnt); end
      req = '0;
   endtask

   task automatic test_fairness();
      do_reset();
      req = 4'b0001;
      step();
      req = 4'b0000;
      step();
      req = 4'b1001;
      step();
      nvec++; if (gnt !== 4'b1000) begin nerr++; $display("FAIL fair_first got %b want 1000", gnt); end
      req = 4'b0001;
      step();
      step();
      nvec++; if (gnt !== 4'b0001) begin nerr++; $display("FAIL fair_second got %b want 0001", gnt); end
      req = 4'b0000;
   endtask

   task automatic test_seed();
      do_reset();
      req = 4'b0001; seed_load = 1'b1; seed_i = 4'b0000;
      step();
      seed_load = 1'b0;
      nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL seed_nogrant got %b want 0000", gnt); end
      nvec++; if (lfsr_o !== 4'b0001) begin nerr++; $display("FAIL seed_zero got %b want 0001", lfsr_o); end
      step();
      nvec++; if (gnt !== 4'b0001) begin nerr++; $display("FAIL seed_gnt got %b want 0001", gnt); end
      nvec++; if (rnd_o !== 4'b0001) begin nerr++; $display("FAIL seed_rnd got %b want 0001", rnd_o); end
      req = 4'b0000;
      step();
      nvec++; if (lfsr_o !== 4'b0011) begin nerr++; $display("FAIL seed_step got %b want 0011", lfsr_o); end
      req = 4'b0010;
      step();
      nvec++; if (gnt !== 4'b0010) begin nerr++; $display("FAIL seedg_gnt got %b want 0010", gnt); end
      nvec++; if (rnd_o !== 4'b0011) begin nerr++; $display("FAIL seedg_rnd got %b want 0011", rnd_o); end
      req = 4'b0000; seed_load = 1'b1; seed_i = 4'b0111;
      step();
      seed_load = 1'b0;
      nvec++; if (lfsr_o !== 4'b0111) begin nerr++; $display("FAIL seedg_lfsr got %b want 0111", lfsr_o); end
      nvec++; if (serve_cnt !== 8'd2) begin nerr++; $display("FAIL seedg_cnt got %0d want 2", serve_cnt); end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req = 4'b0001;
      step();
      step();
      step();
      nvec++; if (rnd_o !== 4'b0101) begin nerr++; $display("FAIL rmg_pre_rnd got %b want 0101", rnd_o); end
      reset = 1'b1; req = 4'b0000;
      step();
      reset = 1'b0;
      nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL rmg_gnt got %b want 0000", gnt); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmg_busy got %b want 0", busy); end
      nvec++; if (rnd_o !== 4'b0000) begin nerr++; $display("FAIL rmg_rnd got %b want 0000", rnd_o); end
      nvec++; if (lfsr_o !== 4'b1010) begin nerr++; $display("FAIL rmg_lfsr got %b want 1010", lfsr_o); end
      nvec++; if (serve_cnt !== 8'd0) begin nerr++; $display("FAIL rmg_cnt got %0d want 0", serve_cnt); end
      req = 4'b0100;
      step();
      nvec++; if (gnt !== 4'b0100) begin nerr++; $display("FAIL rmg_post_gnt got %b want 0100", gnt); end
      nvec++; if (rnd_o !== 4'b1010) begin nerr++; $display("FAIL rmg_post_rnd got %b want 1010", rnd_o); end
      req = 4'b0000;
   endtask

   task automatic test_period();
      logic [3:0] vals [16];
      logic [15:0] seen = '0;
      logic [3:0] m = 4'b1010;
      int n = 0;
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 34 && n < 16; c++) begin
         step();
         if (gnt !== 4'b0000) begin
            vals[n] = rnd_o;
            n++;
         end
      end
      req = 4'b0000;
      nvec++; if (n !== 16) begin nerr++; $display("FAIL period_grants got %0d want 16", n); end
      for (int k = 0; k < 15 && k < n; k++) begin
         nvec++; if (vals[k] !== m || vals[k] == 4'b0000 || seen[vals[k]]) begin nerr++; $display("FAIL period_val%0d got %b want %b unique nonzero", k, vals[k], m); end
         seen[vals[k]] = 1'b1;
         m = {m[2:0], m[3] ^ m[0]};
      end
      if (n == 16) begin
         nvec++; if (vals[15] !== 4'b1010) begin nerr++; $display("FAIL period_wrap got %b want 1010", vals[15]); end
      end
   endtask

   task automatic test_cnt_wrap();
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 510; c++) step();
      nvec++; if (serve_cnt !== 8'd255) begin nerr++; $display("FAIL wrap_max got %0d want 255", serve_cnt); end
      step();
      step();
      nvec++; if (serve_cnt !== 8'd0) begin nerr++; $display("FAIL wrap_zero got %0d want 0", serve_cnt); end
      req = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_seed();
      test_reset_mid_grant();
      test_period();
      test_cnt_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
